// File: rtl/display_update_controller.sv
// Converts a 16-bit binary sample into four BCD digits using a sequential double-dabble.
// Results are held for HOLD_CYCLES before the next sample is accepted.
module display_update_controller #(
  parameter int         HOLD_CYCLES = 10000,
  parameter bit         BLANK_EN    = 1'b1,
  parameter logic [3:0] BLANK_CODE  = 4'hF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [15:0] in_data,
  output logic        in_ready,
  output logic [3:0]  digit0,
  output logic [3:0]  digit1,
  output logic [3:0]  digit2,
  output logic [3:0]  digit3,
  output logic        ovf,
  output logic        upd_done,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, CONVERT, FINISH, HOLD} state_t;

  localparam logic [15:0] HOLD_LOAD  = 16'(HOLD_CYCLES - 1);
  localparam logic [3:0]  LEAD_RESET = BLANK_EN ? BLANK_CODE : 4'd0;
  localparam logic [3:0]  LAST_ITER  = 4'd13;

  state_t      state_reg, state_next;
  logic [13:0] bin_reg;
  logic [15:0] bcd_reg;
  logic [3:0]  iter_reg;
  logic [15:0] hold_reg;
  logic        ovf_latch_reg;
  logic        ovf_reg;
  logic        upd_done_reg;
  logic [3:0]  digit_reg [4];

  logic [15:0] bcd_adj;
  logic [29:0] shift_next;
  logic [13:0] sat_value;
  logic        in_over;
  logic        blank3, blank2, blank1;

  assign in_over   = (in_data > 16'd9999);
  assign sat_value = in_over ? 14'd9999 : in_data[13:0];

  // Add-3 correction on every nibble that would overflow past 9 when doubled.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_adj
      assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5) ?
                                  bcd_reg[gi*4 +: 4] + 4'd3 : bcd_reg[gi*4 +: 4];
    end
  endgenerate

  assign shift_next = {bcd_adj, bin_reg} << 1;

  assign blank3 = BLANK_EN && (bcd_reg[15:12] == 4'd0);
  assign blank2 = blank3 && (bcd_reg[11:8] == 4'd0);
  assign blank1 = blank2 && (bcd_reg[7:4] == 4'd0);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid) state_next = CONVERT;
      CONVERT: if (iter_reg == LAST_ITER) state_next = FINISH;
      FINISH:  state_next = HOLD;
      HOLD:    if (hold_reg == 16'd0) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      bin_reg       <= '0;
      bcd_reg       <= '0;
      iter_reg      <= '0;
      hold_reg      <= '0;
      ovf_latch_reg <= 1'b0;
      ovf_reg       <= 1'b0;
      upd_done_reg  <= 1'b0;
      digit_reg[0]  <= 4'd0;
      digit_reg[1]  <= LEAD_RESET;
      digit_reg[2]  <= LEAD_RESET;
      digit_reg[3]  <= LEAD_RESET;
    end else begin
      state_reg    <= state_next;
      upd_done_reg <= (state_reg == FINISH);
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            bin_reg       <= sat_value;
            bcd_reg       <= '0;
            iter_reg      <= '0;
            ovf_latch_reg <= in_over;
          end
        end
        CONVERT: begin
          bcd_reg  <= shift_next[29:14];
          bin_reg  <= shift_next[13:0];
          iter_reg <= (iter_reg == LAST_ITER) ? 4'd0 : iter_reg + 4'd1;
        end
        FINISH: begin
          digit_reg[0] <= bcd_reg[3:0];
          digit_reg[1] <= blank1 ? BLANK_CODE : bcd_reg[7:4];
          digit_reg[2] <= blank2 ? BLANK_CODE : bcd_reg[11:8];
          digit_reg[3] <= blank3 ? BLANK_CODE : bcd_reg[15:12];
          ovf_reg      <= ovf_latch_reg;
          hold_reg     <= HOLD_LOAD;
        end
        HOLD: begin
          if (hold_reg != 16'd0) hold_reg <= hold_reg - 16'd1;
        end
        default: ;
      endcase
    end
  end

  assign in_ready = (state_reg == IDLE);
  assign busy     = ~in_ready;
  assign ovf      = ovf_reg;
  assign upd_done = upd_done_reg;
  assign digit0   = digit_reg[0];
  assign digit1   = digit_reg[1];
  assign digit2   = digit_reg[2];
  assign digit3   = digit_reg[3];

endmodule

// File: tb/tb_display_update_controller.sv
// Directed bench for display_update_controller: one blanking instance with a short hold,
// and one non-blanking instance with the minimum hold.
module tb_display_update_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_ready, ovf, upd_done, busy;
  logic [3:0]  digit0, digit1, digit2, digit3;

  logic        in_valid_b = 1'b0;
  logic [15:0] in_data_b = '0;
  logic        in_ready_b, ovf_b, upd_done_b, busy_b;
  logic [3:0]  digit0_b, digit1_b, digit2_b, digit3_b;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  display_update_controller #(.HOLD_CYCLES(4), .BLANK_EN(1'b1), .BLANK_CODE(4'hF)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .digit0(digit0), .digit1(digit1), .digit2(digit2), .digit3(digit3),
    .ovf(ovf), .upd_done(upd_done), .busy(busy)
  );

  display_update_controller #(.HOLD_CYCLES(1), .BLANK_EN(1'b0), .BLANK_CODE(4'hF)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_b), .in_data(in_data_b), .in_ready(in_ready_b),
    .digit0(digit0_b), .digit1(digit1_b), .digit2(digit2_b), .digit3(digit3_b),
    .ovf(ovf_b), .upd_done(upd_done_b), .busy(busy_b)
  );

  task automatic check_val(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end else begin
      $display("ok   %s value=%0h", tag, observed);
    end
  endtask

  function automatic logic [15:0] shown();
    return {digit3, digit2, digit1, digit0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction on the blanking instance, with edge-accurate latency checks.
  task automatic run_main(input string tag, input logic [15:0] value,
                          input logic [15:0] exp_digits, input logic exp_ovf);
    logic [15:0] prev;
    logic        early;
    int          guard;
    guard = 0;
    while (!in_ready && guard < 100) begin
      tick();
      guard++;
    end
    check_val({tag, "_ready"}, 32'(in_ready), 32'd1);
    prev     = shown();
    in_valid = 1'b1;
    in_data  = value;
    tick();
    in_valid = 1'b0;
    in_data  = 16'($urandom);
    check_val({tag, "_busy"}, 32'(busy), 32'd1);
    early = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (upd_done) early = 1'b1;
    end
    check_val({tag, "_held"}, 32'(shown()), 32'(prev));
    check_val({tag, "_no_early_done"}, 32'(early), 32'd0);
    tick();
    check_val({tag, "_done"}, 32'(upd_done), 32'd1);
    check_val({tag, "_digits"}, 32'(shown()), 32'(exp_digits));
    check_val({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf));
    tick();
    check_val({tag, "_done_pulse"}, 32'(upd_done), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   lows;
    int   guard;
    logic seen;

    // Asynchronous reset before any clock edge.
    #2 rst_n = 1'b0;
    #1;
    check_val("rst_ready", 32'(in_ready), 32'd1);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_done", 32'(upd_done), 32'd0);
    check_val("rst_ovf", 32'(ovf), 32'd0);
    check_val("rst_digits", 32'(shown()), 32'h0000FFF0);
    check_val("rst_digits_noblank", 32'({digit3_b, digit2_b, digit1_b, digit0_b}), 32'h0);
    tick();
    tick();
    rst_n = 1'b1;

    run_main("d1234", 16'd1234, 16'h1234, 1'b0);
    run_main("d42", 16'd42, 16'hFF42, 1'b0);
    run_main("d0", 16'd0, 16'hFFF0, 1'b0);
    run_main("d12000", 16'd12000, 16'h9999, 1'b1);
    run_main("d9999", 16'd9999, 16'h9999, 1'b0);

    // Continuous in_valid: acceptances 20 cycles apart, busy-time data ignored.
    guard = 0;
    while (!in_ready && guard < 100) begin
      tick();
      guard++;
    end
    check_val("cont_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = 16'd5;
    tick();
    lows = 0;
    for (int k = 0; k <= 19; k++) begin
      if (k == 1)  in_data = 16'd99;
      if (k == 18) in_data = 16'd6;
      if (!in_ready) lows++;
      if (k == 15) check_val("cont_first_digits", 32'(shown()), 32'h0000FFF5);
      if (k < 19) tick();
    end
    check_val("cont_ready_low_cycles", 32'(lows), 32'd19);
    check_val("cont_ready_at_19", 32'(in_ready), 32'd1);
    tick();
    check_val("cont_second_accept_at_20", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    in_data  = 16'hABCD;
    for (int k = 1; k <= 15; k++) tick();
    check_val("cont_second_done", 32'(upd_done), 32'd1);
    check_val("cont_second_digits", 32'(shown()), 32'h0000FFF6);

    // Reset in the middle of converting 8888.
    guard = 0;
    while (!in_ready && guard < 100) begin
      tick();
      guard++;
    end
    in_valid = 1'b1;
    in_data  = 16'd8888;
    tick();
    in_valid = 1'b0;
    for (int k = 1; k <= 7; k++) tick();
    rst_n = 1'b0;
    #1;
    check_val("midrst_digits", 32'(shown()), 32'h0000FFF0);
    check_val("midrst_ready", 32'(in_ready), 32'd1);
    check_val("midrst_busy", 32'(busy), 32'd0);
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (upd_done) seen = 1'b1;
    end
    check_val("midrst_no_done", 32'(seen), 32'd0);
    rst_n = 1'b1;
    run_main("after_rst7", 16'd7, 16'hFFF7, 1'b0);

    // Non-blanking instance with single-cycle hold.
    check_val("nb_ready", 32'(in_ready_b), 32'd1);
    in_valid_b = 1'b1;
    in_data_b  = 16'd5;
    tick();
    in_valid_b = 1'b0;
    in_data_b  = 16'd7777;
    for (int k = 1; k <= 15; k++) tick();
    check_val("nb_done", 32'(upd_done_b), 32'd1);
    check_val("nb_digits", 32'({digit3_b, digit2_b, digit1_b, digit0_b}), 32'h00000005);
    check_val("nb_hold_busy", 32'(in_ready_b), 32'd0);
    tick();
    check_val("nb_hold_one_cycle", 32'(in_ready_b), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/display_update_controller.md
DISPLAY_UPDATE_CONTROLLER -- requirements
Module: display_update_controller

Interface
REQ-001 Parameter HOLD_CYCLES, default 10000: minimum cycles between the end of one display update and acceptance of the next sample; legal range 1..65535.
REQ-002 Parameter BLANK_EN, default 1: 1 enables leading-zero blanking.
REQ-003 Parameter BLANK_CODE, default 4'hF: digit code driven for a blanked digit.
REQ-004 clk  input  1  single system clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  sample offered.
REQ-007 in_data  input  16  unsigned binary sample, for example ALS light level.
REQ-008 in_ready  output  1  controller can accept a sample this cycle.
REQ-009 digit0  output  4  BCD ones digit, or BLANK_CODE.
REQ-010 digit1  output  4  BCD tens digit, or BLANK_CODE.
REQ-011 digit2  output  4  BCD hundreds digit, or BLANK_CODE.
REQ-012 digit3  output  4  BCD thousands digit, or BLANK_CODE.
REQ-013 ovf  output  1  last displayed sample exceeded 9999.
REQ-014 upd_done  output  1  one-cycle pulse when digit0..3 change to a new result.
REQ-015 busy  output  1  high in any state other than IDLE.

Function
REQ-016 The controller SHALL have four states: IDLE, CONVERT, FINISH and HOLD.
REQ-017 in_ready SHALL equal (state==IDLE), and busy SHALL equal its inverse.
REQ-018 Acceptance SHALL occur on a rising edge with in_valid=1 and in_ready=1; the controller then moves IDLE->CONVERT.
REQ-019 On acceptance the controller SHALL latch in_data, saturate it to 9999 if greater than 9999, and latch ovf_next = (in_data>9999).
REQ-020 In IDLE with in_valid=0 the controller SHALL stay in IDLE.
REQ-021 in_valid and in_data SHALL be ignored in every state except IDLE, and in_data changes after acceptance SHALL NOT affect the result.
REQ-022 CONVERT SHALL perform 14 sequential shift-add-3 (double-dabble) iterations, one per clock, on the 14-bit saturated value.
REQ-023 An internal 4-bit iteration counter SHALL run from 0 to 13, and CONVERT->FINISH SHALL occur after iteration 13.
REQ-024 digit0..3 SHALL hold their previous values throughout CONVERT.
REQ-025 In FINISH, on one edge, the controller SHALL:
  - register digit0..3 from the BCD result with blanking applied;
  - register ovf from ovf_next;
  - assert upd_done for exactly one cycle;
  - load the hold counter with HOLD_CYCLES-1;
  - move to HOLD.
REQ-026 Blanking, when BLANK_EN=1: digit3 SHALL be BLANK_CODE if its BCD value is 0; digit2 SHALL be BLANK_CODE if digit3 is blanked and its value is 0; digit1 likewise relative to digit2.
REQ-027 digit0 SHALL never be blanked, so a value of 0 displays as a single "0".
REQ-028 When BLANK_EN=0 all four digits SHALL show raw BCD values, including leading zeros.
REQ-029 HOLD SHALL decrement the hold counter each cycle and move HOLD->IDLE on the edge where the counter equals 0.
REQ-030 For HOLD_CYCLES=1, HOLD SHALL last exactly one cycle.
REQ-031 Latency SHALL be as follows, taking the acceptance edge as edge N:
  - digits change and upd_done rises at edge N+15;
  - in_ready rises at edge N+15+HOLD_CYCLES.
REQ-032 With in_valid held high continuously, successive acceptances SHALL be spaced exactly 15+HOLD_CYCLES+1 cycles apart, counting the IDLE cycle.
REQ-033 Digit outputs SHALL be glitch-free, being register outputs updated only in FINISH.

Reset
REQ-034 While rst_n=0, the following SHALL hold regardless of clk:
  - state=IDLE and in_ready=1;
  - busy=0, upd_done=0, ovf=0;
  - digit0=0;
  - digit1..3 = BLANK_CODE if BLANK_EN=1, else 0;
  - all internal counters and registers cleared.
REQ-035 If reset is asserted mid-CONVERT or mid-HOLD, the in-flight sample SHALL be discarded with no upd_done pulse.
REQ-036 After reset deassertion the controller SHALL accept a sample on the first rising edge with in_valid=1.

Verification
REQ-037 Accept in_data=1234 (BLANK_EN=1) -> at N+15: digit3..0=1,2,3,4, ovf=0, upd_done high for exactly 1 cycle.
REQ-038 Accept in_data=42, then 0 -> first result digit3..0=F,F,4,2; second result F,F,F,0.
REQ-039 Accept in_data=12000, then 9999 -> first result 9,9,9,9 with ovf=1; second result 9,9,9,9 with ovf=0.
REQ-040 in_valid held high, HOLD_CYCLES=4, data 5 then 6 -> second acceptance 20 cycles after first; in_ready low for 19 cycles between; data presented while busy is not captured.
REQ-041 Assert rst_n=0 at iteration 7 of converting 8888 -> outputs immediately at reset values, no upd_done; after release, accepting 7 yields F,F,F,7.
REQ-042 BLANK_EN=0, accept 5 -> digit3..0=0,0,0,5.
